traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100_000_000: clk cycles per one-second tick (10 ns clk).
REQ-002 Parameter G_TIME, default 30: green duration in seconds.
REQ-003 Parameter Y_TIME, default 5: yellow duration in seconds.
REQ-004 Parameter R_TIME, default 2: all-red clearance duration in seconds.
REQ-005 Parameter WALK_TIME, default 10: pedestrian walk duration in seconds.
REQ-006 clk  input  1  system clock; the block SHALL have one clock; all flops on posedge clk.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ped_req  input  1  pedestrian request, sampled every clk; any high cycle counts as a request.
REQ-009 ns_light  output  3  north-south lamp {red,yellow,green}, one-hot.
REQ-010 ew_light  output  3  east-west lamp {red,yellow,green}, one-hot.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 ped_ack  output  1  one-cycle pulse when a pending request is served.
REQ-013 count  output  6  seconds remaining in current state, for the display.
REQ-014 tick  output  1  one-cycle pulse per second, for the display.

Function
REQ-015 The tick divider SHALL count 0..TICKS_PER_SEC-1, wrap to 0, and assert tick for exactly the cycle where it holds TICKS_PER_SEC-1.
REQ-016 States SHALL be NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, WALK.
REQ-017 Durations: NS_G/EW_G=G_TIME, NS_Y/EW_Y=Y_TIME, AR1/AR2=R_TIME, WALK=WALK_TIME.
REQ-018 Lamps: NS_G ns=green, ew=red; NS_Y ns=yellow, ew=red; EW_G ew=green, ns=red; EW_Y ew=yellow, ns=red; AR1/AR2/WALK both red.
REQ-019 walk SHALL be 1 only in WALK.
REQ-020 On a tick with count>1, count SHALL decrement by 1; without a tick, count SHALL hold.
REQ-021 On a tick with count==1, the state SHALL advance and count SHALL load the new state's duration on the same edge; count SHALL never read 0.
REQ-022 Transitions: NS_G->NS_Y->(WALK if pending, else AR1); EW_G->EW_Y->(WALK if pending, else AR2); AR1->EW_G; AR2->NS_G.
REQ-023 WALK SHALL exit to AR1 when entered from NS_Y and to AR2 when entered from EW_Y; a 1-bit return flag SHALL record the direction.
REQ-024 A pending flag SHALL be set on any cycle with ped_req=1 and cleared on the edge that enters WALK.
REQ-025 When set and clear coincide, set SHALL win: pending stays 1 and is served at the next yellow end.
REQ-026 ped_ack SHALL be 1 for exactly the first cycle in WALK.
REQ-027 ped_req while in WALK SHALL not extend WALK; it is only latched as pending.
REQ-028 Durations SHALL be 1..63; a value of 0 or above 63 is illegal and SHALL fail elaboration.
REQ-029 All outputs SHALL be registered; no combinational path from ped_req to any output.

Reset
REQ-030 While rst=1: state=AR2, count=R_TIME, ns_light=ew_light=red, walk=0, ped_ack=0, tick=0, divider=0, pending=0, return flag=0.
REQ-031 Asserting rst mid-operation SHALL force the REQ-030 values immediately, without waiting for a clk edge.
REQ-032 After rst falls, the first NS_G SHALL begin after R_TIME ticks.

Structure
REQ-033 Package traffic_pkg SHALL hold the state enumeration, the lamp encodings (RED=3'b100, YELLOW=3'b010, GREEN=3'b001) and the default durations.
REQ-034 Sub-module tick_gen SHALL implement REQ-015 with parameter TICKS_PER_SEC and ports clk, rst, tick.
REQ-035 The FSM, timer and pending logic SHALL live in traffic_light_ctrl.

Verification (TICKS_PER_SEC=4, G_TIME=3, Y_TIME=2, R_TIME=1, WALK_TIME=2)
REQ-036 Release rst, no ped_req -> both red, count=1; at clk 4 tick -> NS_G, count=3, ns=001.
REQ-037 Free-run, no ped_req -> one full cycle of NS_G,NS_Y,AR1,EW_G,EW_Y,AR2 lasts 12 ticks (48 clk); count runs 3,2,1 / 2,1 / 1; never 0.
REQ-038 One-cycle ped_req during NS_G -> after NS_Y: WALK, ped_ack=1 for 1 cycle, walk=1 for 8 clk; then AR1, then EW_G.
REQ-039 ped_req high on the cycle that enters WALK -> pending remains 1; a second WALK follows EW_Y, then AR2.
REQ-040 rst pulse mid-EW_G -> ns=ew=100, count=1, walk=0 before the next clk edge; normal sequence resumes from AR2.
REQ-041 ped_req held high for 20 clk spanning WALK -> WALK lasts exactly 2 ticks; one more WALK after the next yellow.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: state set,
// lamp encodings and the default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        AR1,
        EW_G,
        EW_Y,
        AR2,
        WALK
    } state_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int TICKS_PER_SEC_DEF = 100_000_000;
    localparam int G_TIME_DEF        = 30;
    localparam int Y_TIME_DEF        = 5;
    localparam int R_TIME_DEF        = 2;
    localparam int WALK_TIME_DEF     = 10;

    localparam int CNT_W = 6;

    // Durations must fit the 6-bit display counter and never be zero.
    function automatic logic dur_ok(input int d);
        return (d >= 1) && (d <= 63);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Pedestrian request input plus lamp/display outputs of the controller.
// master = surrounding logic, slave = the controller.
interface traffic_light_ctrl_if;
    import traffic_pkg::*;

    logic             ped_req;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic             walk;
    logic             ped_ack;
    logic [CNT_W-1:0] count;
    logic             tick;

    modport master (
        output ped_req,
        input  ns_light, ew_light, walk, ped_ack, count, tick
    );

    modport slave (
        input  ped_req,
        output ns_light, ew_light, walk, ped_ack, count, tick
    );

endinterface

// File: rtl/tick_gen.sv
// Divides clk down to a registered one-cycle pulse once per second.
module tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 1) begin : g_bad_ticks
        $error("tick_gen: TICKS_PER_SEC must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q;

    always_comb div_d = (div_q == LAST) ? '0 : div_q + DIV_W'(1);

    // tick_q is high exactly while div_q holds LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller with an all-red pedestrian walk phase
// inserted after a yellow whenever a request is pending.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int G_TIME        = G_TIME_DEF,
    parameter int Y_TIME        = Y_TIME_DEF,
    parameter int R_TIME        = R_TIME_DEF,
    parameter int WALK_TIME     = WALK_TIME_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  bus
);

    if (!dur_ok(G_TIME) || !dur_ok(Y_TIME) || !dur_ok(R_TIME) || !dur_ok(WALK_TIME))
    begin : g_bad_duration
        $error("traffic_light_ctrl: every duration must be in 1..63");
    end

    localparam logic [CNT_W-1:0] G_D = CNT_W'(G_TIME);
    localparam logic [CNT_W-1:0] Y_D = CNT_W'(Y_TIME);
    localparam logic [CNT_W-1:0] R_D = CNT_W'(R_TIME);
    localparam logic [CNT_W-1:0] W_D = CNT_W'(WALK_TIME);

    function automatic logic [CNT_W-1:0] dur_of(input state_e s);
        case (s)
            NS_G, EW_G: return G_D;
            NS_Y, EW_Y: return Y_D;
            WALK:       return W_D;
            default:    return R_D;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input state_e s);
        case (s)
            NS_G:    return GREEN;
            NS_Y:    return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_e s);
        case (s)
            EW_G:    return GREEN;
            EW_Y:    return YELLOW;
            default: return RED;
        endcase
    endfunction

    logic tick;

    tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic             ret_q, ret_d;
    logic             enter_walk;
    logic [2:0]       ns_q, ew_q;
    logic             walk_q, ack_q;

    // ret flag: 1 means the walk was entered from EW_Y and exits to AR2.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ret_d      = ret_q;
        enter_walk = 1'b0;
        if (tick) begin
            if (count_q > CNT_W'(1)) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                case (state_q)
                    NS_G: state_d = NS_Y;
                    NS_Y: begin
                        if (pend_q) begin
                            state_d    = WALK;
                            ret_d      = 1'b0;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = AR1;
                        end
                    end
                    AR1:  state_d = EW_G;
                    EW_G: state_d = EW_Y;
                    EW_Y: begin
                        if (pend_q) begin
                            state_d    = WALK;
                            ret_d      = 1'b1;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = AR2;
                        end
                    end
                    AR2:  state_d = NS_G;
                    WALK: state_d = ret_q ? AR2 : AR1;
                    default: state_d = AR2;
                endcase
                count_d = dur_of(state_d);
            end
        end
        // A new request on the entry edge wins over the clear.
        pend_d = bus.ped_req | (pend_q & ~enter_walk);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AR2;
            count_q <= R_D;
            pend_q  <= 1'b0;
            ret_q   <= 1'b0;
            ns_q    <= RED;
            ew_q    <= RED;
            walk_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            ret_q   <= ret_d;
            ns_q    <= ns_lamp(state_d);
            ew_q    <= ew_lamp(state_d);
            walk_q  <= (state_d == WALK);
            ack_q   <= enter_walk;
        end
    end

    assign bus.ns_light = ns_q;
    assign bus.ew_light = ew_q;
    assign bus.walk     = walk_q;
    assign bus.ped_ack  = ack_q;
    assign bus.count    = count_q;
    assign bus.tick     = tick;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench: reset vector table, directed pedestrian/reset
// sequences and random requests checked against a phase-level model.
module tb_traffic_light_ctrl;

    localparam int TPS = 4;
    localparam int GT  = 3;
    localparam int YT  = 2;
    localparam int RT  = 1;
    localparam int WT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    traffic_light_ctrl_if ifc();

    traffic_light_ctrl #(
        .TICKS_PER_SEC (TPS),
        .G_TIME        (GT),
        .Y_TIME        (YT),
        .R_TIME        (RT),
        .WALK_TIME     (WT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miscompares = 0;

    // Phase model: 0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2, 6 WALK.
    int dur[7];
    int m_ph, m_cnt, m_edges;
    bit m_pend, m_ret, m_ack, m_tick;

    typedef struct {
        logic       ped;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       ack;
        logic [5:0] cnt;
        logic       tick;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [2:0] ns_lamp(input int ph);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input int ph);
        case (ph)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [14:0] dut_out();
        return {ifc.ns_light, ifc.ew_light, ifc.walk, ifc.ped_ack, ifc.count, ifc.tick};
    endfunction

    function automatic logic [14:0] model_out();
        return {ns_lamp(m_ph), ew_lamp(m_ph), (m_ph == 6), m_ack, 6'(m_cnt), m_tick};
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b  (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph    = 5;
        m_cnt   = RT;
        m_edges = 0;
        m_pend  = 1'b0;
        m_ret   = 1'b0;
        m_ack   = 1'b0;
        m_tick  = 1'b0;
    endtask

    task automatic model_edge(input bit ped);
        bit enter = 1'b0;
        if (m_tick) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else begin
                if (m_ph == 6) begin
                    m_ph = m_ret ? 5 : 2;
                end else if ((m_ph == 1 || m_ph == 4) && m_pend) begin
                    m_ret = (m_ph == 4);
                    m_ph  = 6;
                    enter = 1'b1;
                end else begin
                    m_ph = (m_ph + 1) % 6;
                end
                m_cnt = dur[m_ph];
            end
        end
        m_pend = ped || (m_pend && !enter);
        m_ack  = enter;
        m_edges++;
        m_tick = ((m_edges % TPS) == TPS - 1);
    endtask

    // Drive ped for one cycle, advance the model on the edge, check at negedge.
    task automatic step(input bit ped);
        ifc.ped_req = ped;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(ped);
        @(negedge clk);
        check("model", dut_out(), model_out());
        check("count_nonzero", 15'(ifc.count == 6'd0), 15'd0);
    endtask

    task automatic run_until(input int ph, input string name);
        int n = 0;
        while (m_ph != ph && n < 200) begin
            step(1'b0);
            n++;
        end
        check(name, 15'(m_ph), 15'(ph));
    endtask

    int walk_cyc, acks, n;

    initial begin
        dur = '{GT, YT, RT, GT, YT, RT, WT};
        tbl[0] = '{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 6'd1, 1'b0};
        tbl[1] = '{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 6'd1, 1'b0};
        tbl[2] = '{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 6'd1, 1'b1};
        tbl[3] = '{1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 6'd3, 1'b0};
        tbl[4] = '{1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 6'd3, 1'b0};
        tbl[5] = '{1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 6'd3, 1'b0};
        tbl[6] = '{1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 6'd3, 1'b1};
        tbl[7] = '{1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 6'd2, 1'b0};

        ifc.ped_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", dut_out(), {3'b100, 3'b100, 1'b0, 1'b0, 6'd1, 1'b0});

        // Release and walk the first cycles against the hand-derived table.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].ped);
            check($sformatf("table[%0d]", i), dut_out(),
                  {tbl[i].ns, tbl[i].ew, tbl[i].walk, tbl[i].ack, tbl[i].cnt, tbl[i].tick});
        end

        // Rest of one full unrequested cycle, then back in NS_G.
        repeat (44) step(1'b0);
        check("full_cycle_ns_green", 15'(ifc.ns_light), 15'(3'b001));

        // One-cycle request during NS_G: one walk of 8 clk, one ack.
        run_until(0, "reach_ns_g_a");
        step(1'b1);
        walk_cyc = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            walk_cyc += int'(ifc.walk);
            acks     += int'(ifc.ped_ack);
        end
        check("single_req_walk_cycles", 15'(walk_cyc), 15'd8);
        check("single_req_acks", 15'(acks), 15'd1);

        // Request coinciding with walk entry keeps pending: second walk after EW_Y.
        run_until(0, "reach_ns_g_b");
        step(1'b1);
        n = 0;
        while (!(m_ph == 1 && m_tick && m_cnt == 1) && n < 200) begin
            step(1'b0);
            n++;
        end
        step(1'b1);
        check("coincide_in_walk", {14'd0, ifc.walk}, 15'd1);
        acks = 0;
        for (int i = 0; i < 48; i++) begin
            step(1'b0);
            acks += int'(ifc.ped_ack);
        end
        check("coincide_second_walk_acks", 15'(acks), 15'd1);

        // Asynchronous reset in the middle of EW_G.
        run_until(3, "reach_ew_g");
        step(1'b0);
        step(1'b0);
        #2 rst = 1'b1;
        #1 check("async_reset", dut_out(), {3'b100, 3'b100, 1'b0, 1'b0, 6'd1, 1'b0});
        model_reset();
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        repeat (30) step(1'b0);

        // Request held for 20 clk spanning a walk: walk not extended, one more walk.
        run_until(0, "reach_ns_g_c");
        step(1'b1);
        n = 0;
        while (!(m_ph == 1 && m_cnt == 1) && n < 200) begin
            step(1'b0);
            n++;
        end
        walk_cyc = 0; acks = 0;
        for (int i = 0; i < 60; i++) begin
            step(i < 20);
            walk_cyc += int'(ifc.walk);
            acks     += int'(ifc.ped_ack);
        end
        check("held_req_walk_cycles", 15'(walk_cyc), 15'd16);
        check("held_req_acks", 15'(acks), 15'd2);

        // Random sparse requests.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
